kf8088_bus_cycle_generator: RTL and testbench

- Bus-master side of the 8088 status protocol. Turns queued transaction requests into 8088-style bus cycles: S2..S0 processor status, multiplexed address/data, READY-extended T-states.
- Drives the processor_status input of the 8288-compatible command decoder; that decoder turns the status into MEMR/MEMW/IOR/IOW/INTA.
- Used by the DMA/test-master path and the CPU-replacement bench in the KFPC-XT platform.

---
 rtl/kf8088_bus_cycle_generator.sv | 177 +++++++++++++++++
 tb/tb_kf8088_bus_cycle_generator.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kf8088_bus_cycle_generator.sv
// 8088-style bus master: converts queued requests into S2..S0 status cycles
// (TI/T1/T2/T3/TW/T4) paced by edges of cpu_clock detected in the clock domain.
module kf8088_bus_cycle_generator #(
  parameter int ADDRESS_WIDTH = 20,
  parameter int DATA_WIDTH    = 8,
  parameter int WAIT_LIMIT    = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cpu_clock,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_type,
  input  logic [ADDRESS_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0]    req_write_data,
  input  logic                     ready,
  input  logic [DATA_WIDTH-1:0]    data_in,
  output logic [2:0]               processor_status,
  output logic [ADDRESS_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     data_out_enable,
  output logic                     done,
  output logic [DATA_WIDTH-1:0]    read_data,
  output logic                     timeout
);

  localparam int WAIT_WIDTH = (WAIT_LIMIT > 127) ? $clog2(WAIT_LIMIT + 2) : 8;

  localparam logic [2:0] STATUS_PASSIVE = 3'b111;
  localparam logic [2:0] STATUS_IOW     = 3'b010;
  localparam logic [2:0] STATUS_HALT    = 3'b011;
  localparam logic [2:0] STATUS_MEMW    = 3'b110;

  typedef enum logic [2:0] {
    TI, T1, T2, T3, TW, T4
  } bus_state_t;

  function automatic logic is_read(input logic [2:0] kind);
    return (kind == 3'b000) || (kind == 3'b001) || (kind == 3'b100) || (kind == 3'b101);
  endfunction

  function automatic logic is_write(input logic [2:0] kind);
    return (kind == STATUS_IOW) || (kind == STATUS_MEMW);
  endfunction

  function automatic logic [WAIT_WIDTH-1:0] wait_increment(input logic [WAIT_WIDTH-1:0] count);
    return (&count) ? count : count + 1'b1;
  endfunction

  bus_state_t                 state;
  logic                       prev_cpu_clock;
  logic                       hold_full;
  logic [2:0]                 hold_type;
  logic [ADDRESS_WIDTH-1:0]   hold_address;
  logic [DATA_WIDTH-1:0]      hold_data;
  logic [2:0]                 active_type;
  logic [DATA_WIDTH-1:0]      active_data;
  logic                       issue_pending;
  logic [WAIT_WIDTH-1:0]      wait_count;

  logic cpu_pos;
  logic cpu_neg;
  logic accept;
  logic limit_reached;
  logic enter_t4;
  logic hit_limit;

  assign cpu_pos       = ~prev_cpu_clock & cpu_clock;
  assign cpu_neg       = prev_cpu_clock & ~cpu_clock;
  // Status 111 is the passive code, never a legal cycle request.
  assign req_ready     = ~hold_full & ~(req_valid & (&req_type));
  assign accept        = req_valid & req_ready;
  assign limit_reached = (WAIT_LIMIT != 0) && (wait_count == WAIT_WIDTH'(WAIT_LIMIT));

  always_comb begin
    enter_t4  = 1'b0;
    hit_limit = 1'b0;
    if (cpu_pos) begin
      case (state)
        T3: enter_t4 = (active_type == STATUS_HALT) || ready;
        TW: begin
          hit_limit = ~ready & limit_reached;
          enter_t4  = ready | hit_limit;
        end
        default: enter_t4 = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= TI;
      prev_cpu_clock   <= 1'b0;
      hold_full        <= 1'b0;
      hold_type        <= STATUS_PASSIVE;
      hold_address     <= '0;
      hold_data        <= '0;
      active_type      <= STATUS_PASSIVE;
      active_data      <= '0;
      issue_pending    <= 1'b0;
      wait_count       <= '0;
      processor_status <= STATUS_PASSIVE;
      address          <= '0;
      data_out         <= '0;
      data_out_enable  <= 1'b0;
      done             <= 1'b0;
      read_data        <= '0;
      timeout          <= 1'b0;
    end else begin
      prev_cpu_clock <= cpu_clock;
      done           <= 1'b0;
      timeout        <= 1'b0;

      if (accept) begin
        hold_full    <= 1'b1;
        hold_type    <= req_type;
        hold_address <= req_address;
        hold_data    <= req_write_data;
      end

      // Falling cpu_clock: issue the held request so the decoder sees status before T1.
      if (cpu_neg) begin
        if ((state == TI || state == T4) && hold_full && !issue_pending) begin
          processor_status <= hold_type;
          address          <= hold_address;
          active_type      <= hold_type;
          active_data      <= hold_data;
          hold_full        <= 1'b0;
          issue_pending    <= 1'b1;
        end
        if (state == T4) begin
          data_out_enable <= 1'b0;
        end
      end

      // Rising cpu_clock: advance the T-state machine.
      if (enter_t4) begin
        state            <= T4;
        processor_status <= STATUS_PASSIVE;
        done             <= 1'b1;
        timeout          <= hit_limit;
        wait_count       <= '0;
        if (is_read(active_type)) begin
          read_data <= data_in;
        end
      end else if (cpu_pos) begin
        case (state)
          TI: begin
            if (issue_pending) begin
              state         <= T1;
              issue_pending <= 1'b0;
            end
          end
          T1: begin
            state <= T2;
            if (is_write(active_type)) begin
              data_out        <= active_data;
              data_out_enable <= 1'b1;
            end
          end
          T2: state <= T3;
          T3: begin
            state      <= TW;
            wait_count <= WAIT_WIDTH'(1);
          end
          TW: wait_count <= wait_increment(wait_count);
          T4: begin
            state         <= issue_pending ? T1 : TI;
            issue_pending <= 1'b0;
          end
          default: state <= TI;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kf8088_bus_cycle_generator.sv
// Bench for kf8088_bus_cycle_generator: directed scenarios plus randomized
// transactions checked against a transaction-level model of the bus protocol.
module tb_kf8088_bus_cycle_generator;

  localparam int AW    = 20;
  localparam int DW    = 8;
  localparam int LIMIT = 4;

  localparam logic [2:0] K_INTA = 3'd0, K_IOR = 3'd1, K_IOW = 3'd2, K_HALT = 3'd3;
  localparam logic [2:0] K_MEMR = 3'd5, K_MEMW = 3'd6, K_IDLE = 3'd7;

  logic          clock = 1'b0;
  logic          reset;
  logic          cpu_clock;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_type;
  logic [AW-1:0] req_address;
  logic [DW-1:0] req_write_data;
  logic          ready;
  logic [DW-1:0] data_in;
  logic [2:0]    processor_status;
  logic [AW-1:0] address;
  logic [DW-1:0] data_out;
  logic          data_out_enable;
  logic          done;
  logic [DW-1:0] read_data;
  logic          timeout;

  kf8088_bus_cycle_generator #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH(DW),
    .WAIT_LIMIT(LIMIT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cpu_clock(cpu_clock),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_type(req_type),
    .req_address(req_address),
    .req_write_data(req_write_data),
    .ready(ready),
    .data_in(data_in),
    .processor_status(processor_status),
    .address(address),
    .data_out(data_out),
    .data_out_enable(data_out_enable),
    .done(done),
    .read_data(read_data),
    .timeout(timeout)
  );

  always #5 clock = ~clock;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_read_data = '0;
  logic [2:0]    p_type;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_read_kind(input logic [2:0] t);
    return t inside {K_INTA, K_IOR, 3'd4, K_MEMR};
  endfunction

  function automatic logic is_write_kind(input logic [2:0] t);
    return t inside {K_IOW, K_MEMW};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic edge_to(input logic level);
    cpu_clock = level;
    tick();
  endtask

  task automatic idle();
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic request(input logic [2:0] t, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    req_type       = t;
    req_address    = a;
    req_write_data = wd;
    req_valid      = 1'b1;
    #1;
    check("req_ready_empty", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    #1;
    check("req_ready_full", req_ready, 1'b0);
  endtask

  task automatic issue_edge(input logic [2:0] t, input logic [AW-1:0] a);
    edge_to(1'b0);
    check("issue_status", processor_status, t);
    check("issue_address", address, a);
    check("issue_frees_hold", req_ready, 1'b1);
  endtask

  // Runs one issued cycle from T1 to the T4 falling edge. nwait is the number of
  // ready-low samples starting at the end of T3.
  task automatic walk(input logic [2:0] t, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input int nwait, input logic [DW-1:0] rdata, input bit pend);
    int   w;
    bit   to;
    logic wr;
    wr = is_write_kind(t);
    w  = (t == K_HALT) ? 0 : ((nwait > LIMIT) ? LIMIT : nwait);
    to = (t != K_HALT) && (nwait > LIMIT);
    for (int k = 1; k <= 4 + w; k++) begin
      if (k >= 4) ready = (t == K_HALT) ? 1'b0 : ((k - 4) >= nwait);
      else        ready = 1'($urandom_range(0, 1));
      data_in = (k == 4 + w) ? rdata : DW'($urandom);
      edge_to(1'b1);
      if (k < 4 + w) begin
        check("status_active", processor_status, t);
        check("done_early", done, 1'b0);
        if (k >= 2) check("doe_pos", data_out_enable, wr);
        if (k == 2 && wr) check("data_out", data_out, wd);
        if (k == 1 && pend) request(p_type, p_addr, p_wdata);
        idle();
        edge_to(1'b0);
        check("status_neg", processor_status, t);
        if (k >= 2) check("doe_neg", data_out_enable, wr);
        idle();
      end else begin
        if (is_read_kind(t)) exp_read_data = rdata;
        check("done_pulse", done, 1'b1);
        check("timeout", timeout, to);
        check("status_t4", processor_status, K_IDLE);
        check("read_data", read_data, exp_read_data);
        check("address_hold", address, a);
        tick();
        check("done_width", done, 1'b0);
        if (wr) check("doe_in_t4", data_out_enable, 1'b1);
        idle();
        edge_to(1'b0);
        check("doe_off_t4_neg", data_out_enable, 1'b0);
        check("status_t4_neg", processor_status, pend ? p_type : K_IDLE);
        if (pend) begin
          check("b2b_address", address, p_addr);
          check("b2b_hold_free", req_ready, 1'b1);
        end
        idle();
      end
    end
  endtask

  task automatic finish_ti();
    ready = 1'($urandom_range(0, 1));
    edge_to(1'b1);
    check("ti_status", processor_status, K_IDLE);
    check("ti_done", done, 1'b0);
    idle();
  endtask

  task automatic do_txn(input logic [2:0] t, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input int nwait, input logic [DW-1:0] rdata);
    request(t, a, wd);
    idle();
    issue_edge(t, a);
    idle();
    walk(t, a, wd, nwait, rdata, 1'b0);
    finish_ti();
  endtask

  task automatic reset_mid(input logic [2:0] t, input logic [AW-1:0] a, input int npos);
    request(t, a, 8'h99);
    issue_edge(t, a);
    for (int k = 1; k <= npos; k++) begin
      ready = 1'b0;
      edge_to(1'b1);
      if (k == 1) request(K_MEMR, 20'h0ABCD, 8'h00);
      if (k < npos) edge_to(1'b0);
    end
    check("doe_before_reset", data_out_enable, is_write_kind(t) && npos >= 2);
    reset = 1'b1;
    #1;
    check("rst_status", processor_status, K_IDLE);
    check("rst_doe", data_out_enable, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_hold_dropped", req_ready, 1'b1);
    tick();
    reset = 1'b0;
    exp_read_data = '0;
    check("rst_read_data", read_data, 8'h00);
    for (int k = 0; k < 3; k++) begin
      ready = 1'b1;
      edge_to(1'b0);
      check("post_rst_status", processor_status, K_IDLE);
      edge_to(1'b1);
      check("post_rst_done", done, 1'b0);
      tick();
      check("post_rst_done_late", done, 1'b0);
    end
  endtask

  initial begin
    bit            chained;
    bit            pend;
    logic [2:0]    t;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;

    reset          = 1'b1;
    cpu_clock      = 1'b0;
    req_valid      = 1'b0;
    req_type       = 3'd0;
    req_address    = '0;
    req_write_data = '0;
    ready          = 1'b0;
    data_in        = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_status", processor_status, K_IDLE);
    check("reset_address", address, 0);
    check("reset_data_out", data_out, 0);
    check("reset_doe", data_out_enable, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_read_data", read_data, 0);
    check("reset_timeout", timeout, 1'b0);
    check("reset_req_ready", req_ready, 1'b1);
    edge_to(1'b1);

    do_txn(K_MEMR, 20'hF0000, 8'h00, 0, 8'h5A);
    do_txn(K_IOW, 20'h00060, 8'hC3, 3, 8'h00);

    // Back-to-back MEMW then IOR with no TI in between.
    p_type = K_IOR; p_addr = 20'h0003F; p_wdata = 8'h00;
    request(K_MEMW, 20'h00400, 8'h11);
    issue_edge(K_MEMW, 20'h00400);
    walk(K_MEMW, 20'h00400, 8'h11, $urandom_range(0, 2), 8'h00, 1'b1);
    walk(K_IOR, 20'h0003F, 8'h00, 0, 8'h7E, 1'b0);
    finish_ti();

    do_txn(K_MEMR, 20'h12345, 8'h00, 9, 8'hA5);
    do_txn(K_HALT, 20'h00000, 8'h00, 3, 8'h3C);

    // Illegal request code is never accepted.
    req_type  = K_IDLE;
    req_valid = 1'b1;
    #1;
    check("idle_code_not_ready", req_ready, 1'b0);
    edge_to(1'b0);
    check("idle_code_status", processor_status, K_IDLE);
    edge_to(1'b1);
    check("idle_code_done", done, 1'b0);
    check("idle_code_still_blocked", req_ready, 1'b0);
    req_valid = 1'b0;
    #1;
    check("idle_code_released", req_ready, 1'b1);

    // Request accepted on the same clock as a TI falling edge waits for the next one.
    req_type = K_MEMW; req_address = 20'h55AA5; req_write_data = 8'hE7;
    req_valid = 1'b1;
    cpu_clock = 1'b0;
    #1;
    check("same_clk_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    check("same_clk_not_issued", processor_status, K_IDLE);
    edge_to(1'b1);
    check("same_clk_still_ti", processor_status, K_IDLE);
    issue_edge(K_MEMW, 20'h55AA5);
    walk(K_MEMW, 20'h55AA5, 8'hE7, 1, 8'h00, 1'b0);
    finish_ti();

    // Randomized transactions, optionally chained back-to-back.
    chained = 1'b0;
    t = K_IOR; a = '0; wd = '0;
    for (int i = 0; i < 24; i++) begin
      if (!chained) begin
        t  = 3'($urandom_range(0, 6));
        a  = AW'($urandom);
        wd = DW'($urandom);
        request(t, a, wd);
        idle();
        issue_edge(t, a);
      end
      pend = (i < 23) && ($urandom_range(0, 1) == 1);
      if (pend) begin
        p_type  = 3'($urandom_range(0, 6));
        p_addr  = AW'($urandom);
        p_wdata = DW'($urandom);
      end
      walk(t, a, wd, $urandom_range(0, 6), DW'($urandom), pend);
      if (pend) begin
        t = p_type; a = p_addr; wd = p_wdata;
        chained = 1'b1;
      end else begin
        finish_ti();
        chained = 1'b0;
      end
    end

    reset_mid(K_INTA, 20'h00008, 5);
    reset_mid(K_MEMW, 20'h00777, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
